corr_peak_detector: RTL and testbench
=====================================

# corr_peak_detector

Timing-acquisition stage directly downstream of the 64-tap sign-bit preamble correlator. Forms an L1 magnitude from the correlator's 7-bit Re/Im outputs each enabled sample. Detects a first correlation peak above threshold, then confirms a second peak one long-training-symbol period later within a tolerance window. On confirmation it emits a one-cycle sync pulse, asserts `locked`, and reports the second peak's magnitude and its offset from the nominal position, for the symbol-timing/FFT-window logic.

## Interface
- `THRESH`, 8'd40: minimum magnitude for a qualifying peak (unsigned, compared with ≥).
- `WIN`, 8: first-peak search window, in samples, counted from the trigger sample.
- `PERIOD`, 64: nominal first-to-second peak spacing, in samples.
- `TOL`, 2: ± tolerance on the spacing. Legal range: 1 ≤ TOL ≤ 7, 1 ≤ WIN ≤ PERIOD−TOL, PERIOD+WIN+TOL ≤ 255.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  sample enable; one sample per `clk` edge with `ena`=1.
- `restart`  in  1  synchronous abort/re-arm; acts on any edge, independent of `ena`.
- `CR_in_Re`  in  7  correlator real output, two's complement.
- `CR_in_Im`  in  7  correlator imaginary output, two's complement.
- `sync_pulse`  out  1  one-`clk` pulse on lock.
- `locked`  out  1  level; high from lock until `restart`/reset.
- `peak_mag`  out  8  magnitude of the confirmed second peak.
- `peak_off`  out  4  signed offset of the second peak: p2 − (p1 + PERIOD), range −TOL..+TOL.

## Operation
- **Magnitude stage (registered on `ena`):** `mag_r` = |Re| + |Im|, 8-bit unsigned. |−64| = 64, so the maximum is 128 and no saturation is needed.
- **Sample counter `scnt`** (8-bit): set to 0 on the trigger sample; increments once per `ena` sample while not in SEARCH/LOCK.
- **FSM states:** SEARCH, PK1, GAP, CONF, LOCK. The FSM advances only on `ena` edges and consumes `mag_r`.
  - **SEARCH:** on `mag_r` ≥ THRESH, go to PK1 with `scnt`=0, `max1`=`mag_r`, `p1`=0.
  - **PK1:** update `max1`/`p1` when `mag_r` > `max1`; strict comparison, so on ties the earliest sample wins. After the sample with `scnt`=WIN−1, go to GAP.
  - **GAP:** no tracking. When the next sample has `scnt` = p1+PERIOD−TOL, enter CONF, which then processes that sample. If that index is WIN, PK1 goes straight to CONF.
  - **CONF:** window `scnt` ∈ [p1+PERIOD−TOL, p1+PERIOD+TOL].
    - A sample qualifies if `mag_r` ≥ THRESH.
    - Track `max2`/`p2` among qualifying samples only, with strict > (earliest wins ties).
    - On the last window sample: if any sample qualified, go to LOCK, load `peak_mag`=`max2` and `peak_off`=`p2`−`p1`−PERIOD, and set `sync_pulse`. Otherwise go to SEARCH with no pulse.
  - **LOCK:** `locked`=1. Inputs are ignored and the magnitude stage keeps running. Leave only on `restart`.
- **`restart`=1 on any edge:** FSM→SEARCH, `scnt`/`max1`/`max2` cleared, `locked`→0, `sync_pulse`→0.
  - `peak_mag`/`peak_off` hold their last values.
  - `restart` overrides a simultaneous lock event: no pulse, no load.
- **Reset (`rst`=0):** FSM=SEARCH; `mag_r`, counters, `max1`/`max2`, `sync_pulse`, `locked`, `peak_mag`, `peak_off` all 0.
- **Failed confirmation:** the first sample after the window is evaluated in SEARCH and may re-trigger immediately.

## Timing
- Sample s is captured into `mag_r` at its `ena` edge and consumed by the FSM at the next `ena` edge.
- `sync_pulse` and `locked` rise at the `ena` edge that consumes the last CONF-window sample.
- `sync_pulse` falls at the next `clk` edge regardless of `ena`, so it is exactly 1 `clk` wide.
- `peak_mag`/`peak_off` are valid in the same cycle as `sync_pulse` and stable thereafter.
- `ena`=0 freezes `mag_r`, the FSM and `scnt`. Gaps in `ena` do not alter sample indexing.

## Test plan
Defaults: THRESH=40, WIN=8, PERIOD=64, TOL=2; samples are numbered from 0 after reset release.
- **Reset and idle:** reset, then 300 samples of Re=Im=0 → all outputs 0 throughout; `sync_pulse` never asserts.
- **Clean lock:** sample 10 Re=30, Im=−30 (mag 60); sample 74 Re=−29, Im=29 (mag 58); all others 0 → exactly one `sync_pulse`, `locked`=1, `peak_mag`=58, `peak_off`=0; a later mag-100 sample has no effect.
- **Window and offset:** sample 10 mag 50, sample 12 mag 55 (p1=2), sample 78 mag 45 → `peak_off`=+2, `peak_mag`=45. Repeat with the second peak at sample 79 → no pulse, `locked`=0, and re-trigger at sample 79.
- **Ties and limits:** samples 10 and 11 both mag 60, second peak at 72 (Re=−64, Im=−64, mag 128) → `p1`=0, `peak_off`=−2, `peak_mag`=128.
- **`ena` gaps:** repeat the clean-lock case with `ena` toggling at a 1-in-3 duty cycle → identical `peak_mag`/`peak_off`; `sync_pulse` still 1 `clk` wide.
- **Restart:**
  - Assert `restart` during CONF → no pulse; FSM returns to SEARCH.
  - Assert `restart` on the lock edge → no pulse, `locked`=0.
  - Assert async `rst` mid-GAP → all outputs 0 immediately.

Source files
------------

// File: rtl/corr_peak_detector_if.sv
// rtl/corr_peak_detector_if.sv - sample/result bundle between the preamble correlator and the peak detector
//
// Purpose: carries one correlator sample per enabled clock into the peak
// detector, and carries the lock result back to the symbol-timing logic.
//
// Signals:
//   ena        sample enable, one sample per clk edge with ena=1
//   restart    synchronous abort/re-arm, acts on any clk edge
//   CR_in_Re   correlator real output, 7-bit two's complement
//   CR_in_Im   correlator imaginary output, 7-bit two's complement
//   sync_pulse one-clk pulse on lock
//   locked     level, high from lock until restart/reset
//   peak_mag   magnitude of the confirmed second peak
//   peak_off   signed offset of the second peak from its nominal position
//
// Modports:
//   master     sample source / result consumer
//   slave      the peak detector
interface corr_peak_detector_if;
  logic       ena;
  logic       restart;
  logic [6:0] CR_in_Re;
  logic [6:0] CR_in_Im;
  logic       sync_pulse;
  logic       locked;
  logic [7:0] peak_mag;
  logic [3:0] peak_off;

  modport master (
    output ena,
    output restart,
    output CR_in_Re,
    output CR_in_Im,
    input  sync_pulse,
    input  locked,
    input  peak_mag,
    input  peak_off
  );

  modport slave (
    input  ena,
    input  restart,
    input  CR_in_Re,
    input  CR_in_Im,
    output sync_pulse,
    output locked,
    output peak_mag,
    output peak_off
  );
endinterface

// File: rtl/corr_peak_detector.sv
// rtl/corr_peak_detector.sv - two-peak preamble timing acquisition with lock reporting
//
// Purpose: forms an L1 magnitude from each enabled correlator sample, finds
// the strongest above-threshold sample in a short window after a trigger
// (first peak), then looks for a qualifying second peak one training-symbol
// period later within +/-TOL samples. On confirmation it pulses sync_pulse,
// raises locked and reports the second peak's magnitude and offset.
//
// Parameters:
//   THRESH  minimum qualifying magnitude (>=)
//   WIN     first-peak search window length in samples, from the trigger
//   PERIOD  nominal first-to-second peak spacing in samples
//   TOL     +/- tolerance on the spacing
//   Legal: 1 <= TOL <= 7, 1 <= WIN <= PERIOD-TOL, PERIOD+WIN+TOL <= 255
//
// Ports:
//   clk     sole clock, rising edge
//   rst     asynchronous active-low reset
//   bus     corr_peak_detector_if.slave (samples in, lock result out)
module corr_peak_detector #(
  parameter logic [7:0] THRESH = 8'd40,
  parameter int         WIN    = 8,
  parameter int         PERIOD = 64,
  parameter int         TOL    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  corr_peak_detector_if.slave  bus
);

  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    PK1    = 3'd1,
    GAP    = 3'd2,
    CONF   = 3'd3,
    LOCK   = 3'd4
  } state_t;

  // All index arithmetic fits in 8 bits given the legal parameter range:
  // the largest index ever reached is (WIN-1)+PERIOD+TOL <= 254.
  localparam logic [7:0] WIN_LAST = 8'(WIN - 1);
  localparam logic [7:0] LO_OFS   = 8'(PERIOD - TOL);
  localparam logic [7:0] HI_OFS   = 8'(PERIOD + TOL);
  localparam logic [7:0] PER8     = 8'(PERIOD);

  state_t     state_q;
  logic [7:0] mag_q;
  logic [7:0] scnt_q;
  logic [7:0] max1_q;
  logic [7:0] p1_q;
  logic [7:0] max2_q;
  logic [7:0] p2_q;
  logic       found_q;
  logic       sync_pulse_q;
  logic       locked_q;
  logic [7:0] peak_mag_q;
  logic [3:0] peak_off_q;

  logic [7:0] mag_d;
  logic [7:0] cur_idx;
  logic [7:0] nxt_idx;
  logic       qual;
  logic [7:0] max1_d;
  logic [7:0] p1_d;
  logic [7:0] max2_d;
  logic [7:0] p2_d;
  logic       found_d;
  logic [7:0] conf_lo;
  logic [7:0] conf_hi;
  logic [3:0] peak_off_d;

  // |v| for a 7-bit two's complement value; |-64| = 64 needs the 8th bit.
  function automatic logic [7:0] abs7(input logic [6:0] v);
    logic [7:0] sx;
    sx = {v[6], v};
    abs7 = v[6] ? (~sx + 8'd1) : sx;
  endfunction

  always_comb begin
    mag_d   = abs7(bus.CR_in_Re) + abs7(bus.CR_in_Im);
    // scnt_q holds the index of the last consumed sample; the sample being
    // consumed now is one past it.
    cur_idx = scnt_q + 8'd1;
    nxt_idx = scnt_q + 8'd2;
    qual    = (mag_q >= THRESH);

    max1_d = max1_q;
    p1_d   = p1_q;
    if (state_q == PK1 && mag_q > max1_q) begin
      max1_d = mag_q;
      p1_d   = cur_idx;
    end

    // Only qualifying samples compete; the first one always wins because
    // nothing has been found yet, later ones need a strictly larger value.
    max2_d  = max2_q;
    p2_d    = p2_q;
    found_d = found_q;
    if (state_q == CONF && qual && (!found_q || mag_q > max2_q)) begin
      max2_d  = mag_q;
      p2_d    = cur_idx;
      found_d = 1'b1;
    end

    // The window start is judged against p1 including an update on the
    // last PK1 sample, so PK1 can hand straight over to CONF.
    conf_lo    = p1_d + LO_OFS;
    conf_hi    = p1_q + HI_OFS;
    peak_off_d = 4'(p2_d - p1_q - PER8);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEARCH;
      mag_q        <= 8'd0;
      scnt_q       <= 8'd0;
      max1_q       <= 8'd0;
      p1_q         <= 8'd0;
      max2_q       <= 8'd0;
      p2_q         <= 8'd0;
      found_q      <= 1'b0;
      sync_pulse_q <= 1'b0;
      locked_q     <= 1'b0;
      peak_mag_q   <= 8'd0;
      peak_off_q   <= 4'd0;
    end else begin
      // One clk wide regardless of ena.
      sync_pulse_q <= 1'b0;

      // The magnitude stage keeps running in every state, including LOCK.
      if (bus.ena) begin
        mag_q <= mag_d;
      end

      if (bus.restart) begin
        // Overrides any lock event on the same edge; results are held.
        state_q  <= SEARCH;
        scnt_q   <= 8'd0;
        max1_q   <= 8'd0;
        max2_q   <= 8'd0;
        found_q  <= 1'b0;
        locked_q <= 1'b0;
      end else if (bus.ena) begin
        case (state_q)
          SEARCH: begin
            if (qual) begin
              scnt_q  <= 8'd0;
              max1_q  <= mag_q;
              p1_q    <= 8'd0;
              max2_q  <= 8'd0;
              found_q <= 1'b0;
              // With a one-sample window the trigger is also the last
              // first-peak sample.
              if (WIN == 1) begin
                state_q <= (LO_OFS == 8'd1) ? CONF : GAP;
              end else begin
                state_q <= PK1;
              end
            end
          end

          PK1: begin
            scnt_q <= cur_idx;
            max1_q <= max1_d;
            p1_q   <= p1_d;
            if (cur_idx == WIN_LAST) begin
              state_q <= (nxt_idx == conf_lo) ? CONF : GAP;
            end
          end

          GAP: begin
            scnt_q <= cur_idx;
            if (nxt_idx == conf_lo) begin
              state_q <= CONF;
            end
          end

          CONF: begin
            scnt_q  <= cur_idx;
            max2_q  <= max2_d;
            p2_q    <= p2_d;
            found_q <= found_d;
            if (cur_idx == conf_hi) begin
              if (found_d) begin
                state_q      <= LOCK;
                peak_mag_q   <= max2_d;
                peak_off_q   <= peak_off_d;
                sync_pulse_q <= 1'b1;
                locked_q     <= 1'b1;
              end else begin
                // The next sample is evaluated in SEARCH and may re-trigger.
                state_q <= SEARCH;
              end
            end
          end

          LOCK: begin
            state_q <= LOCK;
          end

          default: begin
            state_q <= SEARCH;
          end
        endcase
      end
    end
  end

  assign bus.sync_pulse = sync_pulse_q;
  assign bus.locked     = locked_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_off   = peak_off_q;

endmodule

// File: tb/tb_corr_peak_detector.sv
// tb/tb_corr_peak_detector.sv - self-checking bench for corr_peak_detector with a lock-result scoreboard
module tb_corr_peak_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  corr_peak_detector_if bus ();

  corr_peak_detector #(
    .THRESH(8'd40),
    .WIN   (8),
    .PERIOD(64),
    .TOL   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] mag;
    logic [3:0] off;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int   checks = 0;
  int   errors = 0;
  int   npulse = 0;
  logic prev_pulse = 1'b0;
  int   sidx = 0;

  logic [6:0] re_a [0:511];
  logic [6:0] im_a [0:511];
  bit         rs_a [0:511];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 512; i++) begin
      re_a[i] = 7'd0;
      im_a[i] = 7'd0;
      rs_a[i] = 1'b0;
    end
  endtask

  task automatic set_s(input int i, input int re, input int im);
    re_a[i] = 7'(re);
    im_a[i] = 7'(im);
  endtask

  task automatic expect_lock(input int mag, input int off);
    exp_t e;
    e.mag = 8'(mag);
    e.off = 4'(off);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    bus.ena      = 1'b0;
    bus.restart  = 1'b0;
    bus.CR_in_Re = 7'd0;
    bus.CR_in_Im = 7'd0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    npulse = 0;
    sidx   = 0;
    rst    = 1'b1;
  endtask

  // Drives samples sidx..last, one enabled edge each, followed by duty-1
  // idle edges; ends one edge after the last sample has been captured.
  task automatic run_to(input int last, input int duty);
    while (sidx <= last) begin
      @(negedge clk);
      bus.ena      = 1'b1;
      bus.CR_in_Re = re_a[sidx];
      bus.CR_in_Im = im_a[sidx];
      bus.restart  = rs_a[sidx];
      sidx++;
      for (int k = 1; k < duty; k++) begin
        @(negedge clk);
        bus.ena     = 1'b0;
        bus.restart = 1'b0;
      end
    end
    @(negedge clk);
    bus.ena     = 1'b0;
    bus.restart = 1'b0;
  endtask

  // Scoreboard consumer: every sync_pulse pops one expected lock result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.sync_pulse === 1'b1) begin
          npulse++;
          if (exp_q.size() == 0) begin
            check("spurious_pulse", 32'(bus.sync_pulse), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("pulse_peak_mag", 32'(bus.peak_mag), 32'(mon_e.mag));
            check("pulse_peak_off", 32'(bus.peak_off), 32'(mon_e.off));
            check("pulse_locked", 32'(bus.locked), 32'd1);
          end
        end
        if (prev_pulse) begin
          check("pulse_width", 32'(bus.sync_pulse), 32'd0);
        end
        prev_pulse = bus.sync_pulse;
      end else begin
        prev_pulse = 1'b0;
      end
    end
  end

  initial begin
    bus.ena      = 1'b0;
    bus.restart  = 1'b0;
    bus.CR_in_Re = 7'd0;
    bus.CR_in_Im = 7'd0;

    // Reset state
    do_reset();
    check("rst_sync_pulse", 32'(bus.sync_pulse), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("rst_peak_off", 32'(bus.peak_off), 32'd0);

    // Idle: 300 zero samples, outputs stay 0
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      run_to(i, 1);
      check("idle_outputs", 32'({bus.sync_pulse, bus.locked, bus.peak_mag, bus.peak_off}), 32'd0);
    end
    check("idle_pulses", 32'(npulse), 32'd0);

    // Clean lock, then a late strong sample must be ignored
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(74, -29, 29);
    set_s(150, 50, 50);
    expect_lock(58, 0);
    run_to(100, 1);
    check("clean_locked", 32'(bus.locked), 32'd1);
    check("clean_peak_mag", 32'(bus.peak_mag), 32'd58);
    check("clean_peak_off", 32'(bus.peak_off), 32'd0);
    run_to(200, 1);
    check("clean_pulses", 32'(npulse), 32'd1);
    check("clean_late_locked", 32'(bus.locked), 32'd1);
    check("clean_late_peak_mag", 32'(bus.peak_mag), 32'd58);
    check("clean_pending", 32'(exp_q.size()), 32'd0);

    // Window edge: p1=2, second peak at +TOL
    do_reset();
    clear_stim();
    set_s(10, 25, 25);
    set_s(12, 30, -25);
    set_s(78, -20, 25);
    expect_lock(45, 2);
    run_to(120, 1);
    check("win_peak_off", 32'(bus.peak_off), 32'd2);
    check("win_peak_mag", 32'(bus.peak_mag), 32'd45);
    check("win_locked", 32'(bus.locked), 32'd1);
    check("win_pending", 32'(exp_q.size()), 32'd0);

    // Just outside the window: no lock, sample 79 re-triggers
    do_reset();
    clear_stim();
    set_s(10, 25, 25);
    set_s(12, 30, -25);
    set_s(79, -20, 25);
    set_s(143, 20, 22);
    run_to(100, 1);
    check("out_pulses", 32'(npulse), 32'd0);
    check("out_locked", 32'(bus.locked), 32'd0);
    expect_lock(42, 0);
    run_to(200, 1);
    check("retrig_locked", 32'(bus.locked), 32'd1);
    check("retrig_peak_mag", 32'(bus.peak_mag), 32'd42);
    check("retrig_peak_off", 32'(bus.peak_off), 32'd0);
    check("retrig_pending", 32'(exp_q.size()), 32'd0);

    // Tie on first peak keeps the earliest; max magnitude at -TOL
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(11, -30, 30);
    set_s(72, -64, -64);
    expect_lock(128, -2);
    run_to(120, 1);
    check("tie_peak_mag", 32'(bus.peak_mag), 32'd128);
    check("tie_peak_off", 32'(bus.peak_off), 32'hE);
    check("tie_pending", 32'(exp_q.size()), 32'd0);

    // Clean lock with ena at 1-in-3 duty
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(74, -29, 29);
    expect_lock(58, 0);
    run_to(120, 3);
    check("gap_peak_mag", 32'(bus.peak_mag), 32'd58);
    check("gap_peak_off", 32'(bus.peak_off), 32'd0);
    check("gap_pulses", 32'(npulse), 32'd1);
    check("gap_pending", 32'(exp_q.size()), 32'd0);

    // Restart during CONF: no pulse, back to SEARCH, later lock works
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(74, -29, 29);
    rs_a[75] = 1'b1;
    set_s(100, 30, -30);
    set_s(164, -29, 29);
    run_to(90, 1);
    check("rconf_pulses", 32'(npulse), 32'd0);
    check("rconf_locked", 32'(bus.locked), 32'd0);
    expect_lock(58, 0);
    run_to(200, 1);
    check("rconf_relock", 32'(bus.locked), 32'd1);
    check("rconf_relock_pulses", 32'(npulse), 32'd1);
    check("rconf_pending", 32'(exp_q.size()), 32'd0);

    // Restart on the lock edge: no pulse, no load
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(74, -29, 29);
    rs_a[77] = 1'b1;
    run_to(120, 1);
    check("rlock_pulses", 32'(npulse), 32'd0);
    check("rlock_locked", 32'(bus.locked), 32'd0);
    check("rlock_peak_mag", 32'(bus.peak_mag), 32'd0);

    // Lock, restart (results held), re-trigger, async reset mid-GAP
    do_reset();
    clear_stim();
    set_s(10, 30, -30);
    set_s(74, -29, 29);
    expect_lock(58, 0);
    run_to(90, 1);
    check("arst_first_locked", 32'(bus.locked), 32'd1);
    rs_a[95] = 1'b1;
    set_s(110, 30, -30);
    run_to(130, 1);
    check("arst_restart_locked", 32'(bus.locked), 32'd0);
    check("arst_hold_peak_mag", 32'(bus.peak_mag), 32'd58);
    #2;
    rst = 1'b0;
    #1;
    check("arst_outputs", 32'({bus.sync_pulse, bus.locked, bus.peak_mag, bus.peak_off}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check("arst_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
